// File: rtl/k_means_point_loader_if.sv
// Point stream and RAM write bus shared by the k-means point loader and its neighbours.
// The slave side is the loader; the master side is whatever feeds points and watches the RAM pins.
interface k_means_point_loader_if #(
    parameter int dataWidth    = 91,
    parameter int addrWidth    = 9,
    parameter int ram_word_len = 50
);
    logic                    pt_valid;
    logic [dataWidth-1:0]    pt_data;
    logic                    pt_ready;
    logic [addrWidth-1:0]    ram_addr;
    logic                    ram_csb;
    logic                    ram_web;
    logic                    ram_oeb;
    logic [ram_word_len-1:0] ram1_data;
    logic [ram_word_len-1:0] ram2_data;

    modport slave (
        input  pt_valid, pt_data,
        output pt_ready, ram_addr, ram_csb, ram_web, ram_oeb, ram1_data, ram2_data
    );

    modport master (
        output pt_valid, pt_data,
        input  pt_ready, ram_addr, ram_csb, ram_web, ram_oeb, ram1_data, ram2_data
    );
endinterface

// File: rtl/k_means_point_loader.sv
// Streams points into the two k-means RAMs at consecutive (wrapping) addresses, reports the
// address range to the controller and optionally fires go_core once the last write is issued.
module k_means_point_loader #(
    parameter int dataWidth    = 91,
    parameter int addrWidth    = 9,
    parameter int ram_word_len = 50,
    parameter int count_width  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   auto_go,
    input  logic [addrWidth-1:0]   base_addr,
    input  logic [count_width-1:0] num_points,
    k_means_point_loader_if.slave  bus,
    output logic [addrWidth-1:0]   first_ram_addr,
    output logic [addrWidth-1:0]   last_ram_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   go_core,
    output logic                   err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [count_width-1:0] MAX_POINTS = count_width'(1 << addrWidth);
    localparam int HI_W  = dataWidth - ram_word_len;
    localparam int PAD_W = ram_word_len - HI_W;

    // Lower RAM word: the first ram_word_len bits of the point.
    function automatic logic [ram_word_len-1:0] lo_word(input logic [dataWidth-1:0] pt);
        return pt[ram_word_len-1:0];
    endfunction

    // Upper RAM word: the remaining bits, zero-extended to a full RAM word.
    function automatic logic [ram_word_len-1:0] hi_word(input logic [dataWidth-1:0] pt);
        return {{PAD_W{1'b0}}, pt[dataWidth-1:ram_word_len]};
    endfunction

    logic [1:0]             state;
    logic [addrWidth-1:0]   wr_ptr;
    logic [count_width-1:0] k_cnt;
    logic [count_width-1:0] last_k;
    logic                   auto_go_r;

    logic                   start_ok_p0;
    logic                   start_bad_p0;
    logic                   xfer_p0;

    logic                   vld_p1;
    logic [addrWidth-1:0]   ram_addr_p1;
    logic [ram_word_len-1:0] ram1_data_p1;
    logic [ram_word_len-1:0] ram2_data_p1;

    assign start_ok_p0  = (state == IDLE) && start &&
                          (num_points != '0) && (num_points <= MAX_POINTS);
    assign start_bad_p0 = (state == IDLE) && start && !start_ok_p0;
    assign xfer_p0      = bus.pt_valid && bus.pt_ready;

    assign bus.pt_ready  = (state == LOAD);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign go_core       = (state == DONE) && auto_go_r;

    // Stage p0 -> p1: RAM pins driven from the registered transfer.
    assign bus.ram_addr  = ram_addr_p1;
    assign bus.ram_csb   = ~vld_p1;
    assign bus.ram_web   = ~vld_p1;
    assign bus.ram_oeb   = 1'b1;
    assign bus.ram1_data = ram1_data_p1;
    assign bus.ram2_data = ram2_data_p1;

    // Load sequencing: latch the job on a legal start, count transfers, finish after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            k_cnt          <= '0;
            last_k         <= '0;
            auto_go_r      <= 1'b0;
            first_ram_addr <= '0;
            last_ram_addr  <= '0;
            err            <= 1'b0;
        end else begin
            err <= start_bad_p0;
            case (state)
                IDLE: begin
                    if (start_ok_p0) begin
                        state          <= LOAD;
                        wr_ptr         <= base_addr;
                        k_cnt          <= '0;
                        last_k         <= num_points - count_width'(1);
                        auto_go_r      <= auto_go;
                        first_ram_addr <= base_addr;
                        // A 512-point load truncates to 0 here, giving base-1 mod 512 as required.
                        last_ram_addr  <= base_addr + num_points[addrWidth-1:0] - addrWidth'(1);
                    end
                end
                LOAD: begin
                    if (xfer_p0) begin
                        wr_ptr <= wr_ptr + addrWidth'(1);
                        k_cnt  <= k_cnt + count_width'(1);
                        if (k_cnt == last_k) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write register: capture the accepted point and its address; strobe only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            ram_addr_p1  <= '0;
            ram1_data_p1 <= '0;
            ram2_data_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                ram_addr_p1  <= wr_ptr;
                ram1_data_p1 <= lo_word(bus.pt_data);
                ram2_data_p1 <= hi_word(bus.pt_data);
            end
        end
    end

endmodule
